// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter that shares one L2 port among NUM_PORTS L1 requesters.
// One transaction at a time: IDLE -> ISSUE (one-cycle strobe) -> WAIT (ready or timeout) -> RESP.
module l2_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_SIZE = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             p_rd,
    input  logic [NUM_PORTS-1:0]             p_wr,
    input  logic [NUM_PORTS*32-1:0]          p_addr,
    input  logic [NUM_PORTS*LINE_SIZE*8-1:0] p_wdata,
    output logic [LINE_SIZE*8-1:0]           p_rdata,
    output logic [NUM_PORTS-1:0]             p_ready,
    output logic                             p_err,
    output logic [31:0]                      l2_addr,
    output logic [LINE_SIZE*8-1:0]           l2_wdata,
    output logic                             l2_rd,
    output logic                             l2_wr,
    input  logic [LINE_SIZE*8-1:0]           l2_rdata,
    input  logic                             l2_ready,
    output logic                             busy,
    output logic [1:0]                       grant_id
);

    localparam int LW = LINE_SIZE * 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [1:0]            r_last_grant;
    logic [1:0]            r_grant_id;
    logic [15:0]           r_wait_cnt;
    logic                  r_l2_rd;
    logic                  r_l2_wr;
    logic [31:0]           r_l2_addr;
    logic [LW-1:0]         r_l2_wdata;
    logic [LW-1:0]         r_p_rdata;
    logic [NUM_PORTS-1:0]  r_p_ready;
    logic                  r_p_err;
    logic                  r_busy;

    logic [NUM_PORTS-1:0]  w_req;
    logic                  w_found;
    logic                  w_hit;
    logic [1:0]            w_winner;
    int                    w_idx;
    logic [31:0]           w_addr_sel;
    logic [LW-1:0]         w_wdata_sel;
    logic                  w_sel_rd;
    logic                  w_sel_wr;
    logic [NUM_PORTS-1:0]  w_grant_oh;

    assign w_req = p_rd | p_wr;

    // Round-robin search starting one past the last granted port
    always_comb begin
        w_found  = 1'b0;
        w_hit    = 1'b0;
        w_winner = 2'd0;
        w_idx    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = int'(r_last_grant) + 1 + i;
            w_idx = (w_idx >= NUM_PORTS) ? (w_idx - NUM_PORTS) : w_idx;
            for (int j = 0; j < NUM_PORTS; j++) begin
                w_hit    = (~w_found) & 1'(w_req >> j) & (j == w_idx);
                w_winner = w_hit ? 2'(j) : w_winner;
                w_found  = w_found | w_hit;
            end
        end
    end

    // Operand mux for the winner and one-hot decode of the served port
    always_comb begin
        w_addr_sel  = 32'd0;
        w_wdata_sel = '0;
        w_sel_rd    = 1'b0;
        w_sel_wr    = 1'b0;
        w_grant_oh  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_addr_sel  = w_addr_sel  | ({32{2'(k) == w_winner}} & 32'(p_addr >> (32 * k)));
            w_wdata_sel = w_wdata_sel | ({LW{2'(k) == w_winner}} & LW'(p_wdata >> (LW * k)));
            w_sel_rd    = w_sel_rd | ((2'(k) == w_winner) & 1'(p_rd >> k));
            w_sel_wr    = w_sel_wr | ((2'(k) == w_winner) & 1'(p_wr >> k));
            w_grant_oh  = w_grant_oh | (NUM_PORTS'(2'(k) == r_grant_id) << k);
        end
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 2'(NUM_PORTS - 1);
            r_grant_id   <= 2'd0;
            r_wait_cnt   <= 16'd0;
            r_l2_rd      <= 1'b0;
            r_l2_wr      <= 1'b0;
            r_l2_addr    <= 32'd0;
            r_l2_wdata   <= '0;
            r_p_rdata    <= '0;
            r_p_ready    <= '0;
            r_p_err      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state      <= S_ISSUE;
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_l2_addr    <= w_addr_sel;
                        r_l2_wdata   <= w_wdata_sel;
                        // A simultaneous read and write is forwarded as a write
                        r_l2_wr      <= w_sel_wr;
                        r_l2_rd      <= w_sel_rd & ~w_sel_wr;
                        r_busy       <= 1'b1;
                    end else begin
                        r_busy       <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_state    <= S_WAIT;
                    r_l2_rd    <= 1'b0;
                    r_l2_wr    <= 1'b0;
                    r_wait_cnt <= 16'd0;
                end
                S_WAIT: begin
                    if (l2_ready) begin
                        r_state   <= S_RESP;
                        r_p_rdata <= l2_rdata;
                        r_p_err   <= 1'b0;
                        r_p_ready <= w_grant_oh;
                    end else if (r_wait_cnt == 16'(TIMEOUT - 1)) begin
                        r_state   <= S_RESP;
                        r_p_rdata <= '0;
                        r_p_err   <= 1'b1;
                        r_p_ready <= w_grant_oh;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_p_ready <= '0;
                    r_p_err   <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_l2_rd   <= 1'b0;
                    r_l2_wr   <= 1'b0;
                    r_p_ready <= '0;
                    r_p_err   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign p_rdata  = r_p_rdata;
    assign p_ready  = r_p_ready;
    assign p_err    = r_p_err;
    assign l2_addr  = r_l2_addr;
    assign l2_wdata = r_l2_wdata;
    assign l2_rd    = r_l2_rd;
    assign l2_wr    = r_l2_wr;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-timeline model.
module tb_l2_port_arbiter;

    localparam int NP = 3;
    localparam int LS = 4;
    localparam int LW = LS * 8;
    localparam int TO = 8;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic [NP-1:0]     p_rd     = '0;
    logic [NP-1:0]     p_wr     = '0;
    logic [NP*32-1:0]  p_addr   = '0;
    logic [NP*LW-1:0]  p_wdata  = '0;
    logic [LW-1:0]     p_rdata;
    logic [NP-1:0]     p_ready;
    logic              p_err;
    logic [31:0]       l2_addr;
    logic [LW-1:0]     l2_wdata;
    logic              l2_rd;
    logic              l2_wr;
    logic [LW-1:0]     l2_rdata = '0;
    logic              l2_ready = 1'b0;
    logic              busy;
    logic [1:0]        grant_id;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    l2_port_arbiter #(.NUM_PORTS(NP), .LINE_SIZE(LS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ready(p_ready), .p_err(p_err), .l2_addr(l2_addr),
        .l2_wdata(l2_wdata), .l2_rd(l2_rd), .l2_wr(l2_wr), .l2_rdata(l2_rdata),
        .l2_ready(l2_ready), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    int              m_last = NP - 1;
    int              m_gid  = 0;
    int              m_gcyc = 0;
    int              m_rcyc = -1;
    int              m_p;
    bit              m_act = 1'b0;
    bit              m_rd = 1'b0;
    bit              m_wr = 1'b0;
    bit              m_err = 1'b0;
    bit              m_found;
    logic [31:0]     m_addr  = '0;
    logic [LW-1:0]   m_wdata = '0;
    logic [LW-1:0]   m_rdata = '0;
    logic [NP-1:0]   m_exp_rdy;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_strobe", {l2_rd, l2_wr}, 0);
                chk("rst_p_ready", p_ready, 0);
                chk("rst_p_err", p_err, 0);
                chk("rst_grant_id", grant_id, 0);
                chk("rst_l2_addr", l2_addr, 0);
                chk("rst_l2_wdata", l2_wdata, 0);
                chk("rst_p_rdata", p_rdata, 0);
                m_act = 1'b0; m_last = NP - 1; m_gid = 0; m_rcyc = -1;
                m_addr = '0; m_wdata = '0; m_rdata = '0;
            end else begin
                m_exp_rdy = '0;
                if (m_act && cyc == m_rcyc) m_exp_rdy = NP'(1) << m_gid;
                chk("busy", busy, m_act);
                chk("l2_rd", l2_rd, m_act && cyc == m_gcyc + 1 && m_rd);
                chk("l2_wr", l2_wr, m_act && cyc == m_gcyc + 1 && m_wr);
                chk("l2_addr", l2_addr, m_addr);
                chk("l2_wdata", l2_wdata, m_wdata);
                chk("grant_id", grant_id, m_gid);
                chk("p_ready", p_ready, m_exp_rdy);
                chk("p_rdata", p_rdata, m_rdata);
                if (m_exp_rdy != '0) chk("p_err", p_err, m_err);
                if (m_act) begin
                    if (cyc == m_rcyc) begin
                        m_act = 1'b0;
                    end else if (m_rcyc < 0 && cyc >= m_gcyc + 2) begin
                        if (l2_ready) begin
                            m_rdata = l2_rdata; m_err = 1'b0; m_rcyc = cyc + 1;
                        end else if (cyc - (m_gcyc + 2) == TO - 1) begin
                            m_rdata = '0; m_err = 1'b1; m_rcyc = cyc + 1;
                        end
                    end
                end else begin
                    m_found = 1'b0;
                    for (int i = 1; i <= NP; i++) begin
                        m_p = (m_last + i) % NP;
                        if (!m_found && 1'((p_rd | p_wr) >> m_p)) begin
                            m_found = 1'b1; m_act = 1'b1; m_gcyc = cyc; m_rcyc = -1;
                            m_gid = m_p; m_last = m_p;
                            m_addr  = 32'(p_addr >> (32 * m_p));
                            m_wdata = LW'(p_wdata >> (LW * m_p));
                            m_wr = 1'((p_wr) >> m_p);
                            m_rd = 1'(p_rd >> m_p) && !m_wr;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int             l2_lat = 4;
    int             ready_at = -1;
    bit             lat_random = 1'b0;
    bit             stray_random = 1'b0;
    logic [LW-1:0]  resp_data = '0;
    logic [NP-1:0]  dropped = '0;
    logic [NP-1:0]  obs_ready;
    logic           obs_err, obs_busy, obs_l2rd, obs_l2wr, obs_strobe;
    logic [LW-1:0]  obs_rdata, obs_wdata;
    logic [31:0]    obs_addr;
    logic [1:0]     obs_gid;
    int             obs_cyc;

    // Observe the current cycle, then advance into the next one applying L2 and requester reactions
    task automatic cycle();
        @(negedge clk);
        obs_ready = p_ready; obs_err = p_err; obs_busy = busy; obs_l2rd = l2_rd; obs_l2wr = l2_wr;
        obs_strobe = l2_rd | l2_wr; obs_rdata = p_rdata; obs_wdata = l2_wdata; obs_addr = l2_addr;
        obs_gid = grant_id; obs_cyc = cyc;
        if (obs_strobe) begin
            if (lat_random) l2_lat = $urandom_range(1, TO + 3);
            ready_at = (l2_lat > 0) ? cyc + l2_lat : -1;
        end
        @(posedge clk); #1;
        p_rd = p_rd & ~obs_ready;
        p_wr = p_wr & ~obs_ready;
        dropped = obs_ready;
        l2_ready = (cyc == ready_at) || (stray_random && $urandom_range(0, 15) == 0);
        if (cyc == ready_at) ready_at = -1;
        l2_rdata = lat_random ? LW'($urandom) : resp_data;
    endtask

    task automatic req(input int k, input bit rd, input bit wr, input logic [31:0] a, input logic [LW-1:0] d);
        logic [NP*32-1:0] am, av;
        logic [NP*LW-1:0] dm, dv;
        am = '0; am[31:0] = '1; av = '0; av[31:0] = a;
        dm = '0; dm[LW-1:0] = '1; dv = '0; dv[LW-1:0] = d;
        p_addr  = (p_addr & ~(am << (32 * k))) | (av << (32 * k));
        p_wdata = (p_wdata & ~(dm << (LW * k))) | (dv << (LW * k));
        p_rd = p_rd | (NP'(rd) << k);
        p_wr = p_wr | (NP'(wr) << k);
    endtask

    int            r_lat, r_s2r, r_nrd, r_nwr;
    logic          r_got, r_err;
    logic [31:0]   r_addr;
    logic [LW-1:0] r_wdata, r_rdata;

    // One complete transaction on port k; records what the DUT showed
    task automatic run_one(input int k, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [LW-1:0] d, input int lat);
        int start, scyc;
        cycle();
        l2_lat = lat;
        req(k, rd, wr, a, d);
        start = cyc; scyc = -1; r_got = 1'b0; r_nrd = 0; r_nwr = 0;
        for (int i = 0; i < 40 && !r_got; i++) begin
            cycle();
            r_nrd += int'(obs_l2rd); r_nwr += int'(obs_l2wr);
            if (obs_strobe && scyc < 0) begin
                scyc = obs_cyc; r_addr = obs_addr; r_wdata = obs_wdata;
            end
            if (1'(obs_ready >> k)) begin
                r_got = 1'b1; r_lat = obs_cyc - start + 1; r_s2r = obs_cyc - scyc;
                r_err = obs_err; r_rdata = obs_rdata;
            end
        end
        chk("txn_completed", r_got, 1);
    endtask

    int  gseq[4];
    int  ns, lastp, nr, nb, t;
    bit  found;

    initial begin
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        chk("reset_busy", obs_busy, 0);
        chk("reset_grant", obs_gid, 0);

        // Stray ready while idle
        l2_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stray_busy", obs_busy, 0);
            chk("stray_ready", obs_ready, 0);
        end

        // Single read, L2 answers 4 cycles after the strobe
        resp_data = 32'hA5A5_A5A5;
        run_one(0, 1'b1, 1'b0, 32'h0000_1000, '0, 4);
        chk("rd_latency", r_lat, 7);
        chk("rd_strobe_cycles", r_nrd, 1);
        chk("rd_no_write", r_nwr, 0);
        chk("rd_addr", r_addr, 32'h0000_1000);
        chk("rd_err", r_err, 0);
        chk("rd_data", r_rdata, 32'hA5A5_A5A5);

        // Read+write on port1 becomes a write
        resp_data = 32'h1111_1111;
        run_one(1, 1'b1, 1'b1, 32'h0000_0040, 32'h3C3C_3C3C, 3);
        chk("rw_wr_cycles", r_nwr, 1);
        chk("rw_no_read", r_nrd, 0);
        chk("rw_wdata", r_wdata, 32'h3C3C_3C3C);
        chk("rw_addr", r_addr, 32'h0000_0040);

        // Round robin between continuously requesting ports 0 and 1
        cycle();
        l2_lat = 2; ns = 0; lastp = -100;
        req(0, 1'b1, 1'b0, 32'h100, '0);
        req(1, 1'b1, 1'b0, 32'h200, '0);
        for (int i = 0; i < 100 && ns < 4; i++) begin
            cycle();
            if (obs_strobe) begin
                gseq[ns] = int'(obs_gid);
                if (ns > 0) chk("rr_gap", obs_cyc - lastp, 2);
                ns++;
            end
            if (obs_ready != '0) lastp = obs_cyc;
            if (!p_rd[0] && !dropped[0]) req(0, 1'b1, 1'b0, 32'h100, '0);
            if (!p_rd[1] && !dropped[1]) req(1, 1'b1, 1'b0, 32'h200, '0);
        end
        chk("rr_count", ns, 4);
        for (int i = 0; i < 4; i++) chk("rr_order", gseq[i], i % 2);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            found = ((p_rd | p_wr) == '0) && !obs_busy;
        end
        chk("rr_drain", found, 1);

        // Timeout with silent L2, then ready exactly on the last WAIT cycle
        run_one(0, 1'b1, 1'b0, 32'h2000, '0, 0);
        chk("to_s2r", r_s2r, 9);
        chk("to_err", r_err, 1);
        chk("to_data", r_rdata, 0);
        resp_data = 32'hC3C3_C3C3;
        run_one(0, 1'b1, 1'b0, 32'h2040, '0, 8);
        chk("edge_s2r", r_s2r, 9);
        chk("edge_err", r_err, 0);
        chk("edge_data", r_rdata, 32'hC3C3_C3C3);

        // Reset in the middle of WAIT, old ready arrives afterwards
        cycle();
        l2_lat = 6;
        req(0, 1'b1, 1'b0, 32'h300, '0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = obs_strobe;
        end
        chk("mid_strobe_seen", found, 1);
        cycle(); cycle();
        rst = 1'b1; p_rd = '0; p_wr = '0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rdata", p_rdata, 0);
        cycle();
        rst = 1'b0;
        nr = 0; nb = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (obs_ready != '0) nr++;
            if (obs_busy) nb++;
        end
        chk("mid_rst_no_ready", nr, 0);
        chk("mid_rst_idle", nb, 0);

        // Randomized traffic; the model checks every cycle
        lat_random = 1'b1; stray_random = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            for (int k = 0; k < NP; k++) begin
                if (!1'((p_rd | p_wr) >> k) && !1'(dropped >> k) && $urandom_range(0, 3) == 0) begin
                    t = $urandom_range(0, 2);
                    req(k, t != 1, t != 0, $urandom, LW'($urandom));
                end
            end
            cycle();
        end
        for (int i = 0; i < 40; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of L1 requesters sharing the L2; the legal range is 2..4.
REQ-002 Parameter LINE_SIZE, default 64: line width in bytes; every data bus is LINE_SIZE*8 bits.
REQ-003 Parameter TIMEOUT, default 1024: the maximum number of cycles the arbiter waits for l2_ready; the legal range is 2..65535.
REQ-004 Ports, in order:
- clk  in  1  the single clock.
- rst  in  1  reset, asynchronous and active-high.
- p_rd  in  NUM_PORTS  per-port read request.
- p_wr  in  NUM_PORTS  per-port write request.
- p_addr  in  NUM_PORTS*32  per-port line address; port k occupies bits [32k+31:32k].
- p_wdata  in  NUM_PORTS*LINE_SIZE*8  per-port write line.
- p_rdata  out  LINE_SIZE*8  read line; one bus shared by all ports.
- p_ready  out  NUM_PORTS  per-port one-cycle completion pulse.
- p_err  out  1  timeout flag; valid only while a p_ready bit is high.
- l2_addr  out  32  address to the L2.
- l2_wdata  out  LINE_SIZE*8  write line to the L2.
- l2_rd  out  1  read strobe to the L2.
- l2_wr  out  1  write strobe to the L2.
- l2_rdata  in  LINE_SIZE*8  read line from the L2.
- l2_ready  in  1  one-cycle completion pulse from the L2.
- busy  out  1  high in every state except IDLE.
- grant_id  out  2  index of the port currently being served.

Function
REQ-005 The arbiter SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-006 All outputs SHALL be registered.
REQ-007 Port k is requesting when p_rd[k] or p_wr[k] is high.
- A requester SHALL hold its request and operands stable until its p_ready pulse.
- A requester SHALL deassert its request in the cycle after that pulse.
REQ-008 IDLE, with at least one port requesting: the arbiter SHALL select a winner by round-robin.
- The search starts at port (last_grant+1) mod NUM_PORTS and takes the first requesting port found.
- On that edge the arbiter SHALL latch the winner's address and wdata into l2_addr/l2_wdata, set grant_id, and go to ISSUE.
REQ-009 The last_grant pointer SHALL update to the winner on every grant.
- Its reset value SHALL be NUM_PORTS-1, so that port 0 wins first.
REQ-010 A port with both p_rd and p_wr high SHALL be forwarded as a write only: l2_wr=1, l2_rd=0.
REQ-011 ISSUE SHALL drive l2_rd or l2_wr high for exactly one cycle, then go to WAIT.
- Holding the strobe longer would cause the L2 to re-accept the request on its return to idle.
REQ-012 WAIT: l2_rd and l2_wr SHALL be low.
- A 16-bit counter SHALL start at 0 on entry and increment every cycle.
- On l2_ready=1, the arbiter SHALL capture l2_rdata into p_rdata, clear the error condition, and go to RESP.
- If the counter reaches TIMEOUT-1 with no l2_ready, the arbiter SHALL set p_rdata to all-zeros and the error condition to 1, and go to RESP.
- If l2_ready arrives in the same cycle as the timeout, l2_ready SHALL win: normal completion, p_err=0.
REQ-013 RESP SHALL pulse p_ready[grant_id] high for exactly one cycle, with p_err valid, then go to IDLE.
- Port requests SHALL NOT be evaluated in RESP.
- A new grant therefore issues no earlier than one cycle after RESP.
REQ-014 Minimum latency from request to p_ready is l2_latency+3 cycles, where l2_latency is the number of cycles from the strobe to l2_ready.
- Back-to-back grants SHALL be separated by one IDLE cycle.
REQ-015 A port SHALL wait at most NUM_PORTS-1 other transactions before it is granted (no starvation).
REQ-016 Changes on non-granted ports during ISSUE, WAIT or RESP SHALL have no effect.
REQ-017 Any l2_ready that arrives outside WAIT SHALL be ignored.
REQ-018 p_rdata SHALL hold its last value until the next capture.

Reset
REQ-019 While rst is high, the following SHALL hold immediately and independent of clk:
- state=IDLE, last_grant=NUM_PORTS-1, grant_id=0, wait counter=0.
- l2_rd=0, l2_wr=0, p_ready=0, p_err=0, busy=0.
- l2_addr=0, l2_wdata=0, p_rdata=0.
REQ-020 Reset asserted mid-transaction SHALL abandon that transaction without generating any p_ready.
- The first request after reset release SHALL be granted from IDLE per REQ-008.

Verification
REQ-021 Single read: port0 reads 0x0000_1000; L2 returns 0xA5-filled line 4 cycles after the strobe -> l2_rd high for exactly 1 cycle, l2_addr=0x0000_1000, p_ready[0] pulses 1 cycle with p_rdata=0xA5-filled and p_err=0, latency 7.
REQ-022 Round-robin: ports 0 and 1 request continuously (addresses 0x100/0x200) -> grants alternate 0,1,0,1 over 4 transactions, with exactly one IDLE cycle between grants.
REQ-023 Rd+wr conflict: port1 drives rd=wr=1, addr 0x40, wdata 0x3C-filled -> l2_wr=1, l2_rd=0, l2_wdata=0x3C-filled.
REQ-024 Timeout: TIMEOUT=8 and the L2 never responds -> p_ready[0] pulses with p_err=1 and p_rdata=0 exactly 8 WAIT cycles after the strobe; next case, l2_ready in the 8th WAIT cycle -> p_err=0.
REQ-025 Reset mid-WAIT: rst pulses for 1 cycle during WAIT, then the old L2 ready arrives -> no p_ready, busy=0, and the stray l2_ready is ignored.
REQ-026 Stray ready: l2_ready pulsed while in IDLE -> no state change, all p_ready remain 0.
